// File: rtl/spooky_show_sequencer_if.sv
// Bus bundle for spooky_show_sequencer: sensor/pattern controls in, decoder select and status out.
// master = stimulus side (drives controls), slave = sequencer side.
interface spooky_show_sequencer_if #(
   parameter int unsigned DWELL_W = 16
);
   logic               motion;
   logic [1:0]         mode;
   logic [DWELL_W-1:0] dwell;
   logic               abort;
   logic [3:0]         lamp_idx;
   logic               lamp_en;
   logic               busy;
   logic               done;

   modport master (
      output motion, mode, dwell, abort,
      input  lamp_idx, lamp_en, busy, done
   );

   modport slave (
      input  motion, mode, dwell, abort,
      output lamp_idx, lamp_en, busy, done
   );
endinterface

// File: rtl/spooky_show_sequencer.sv
// Motion-triggered show sequencer: debounced trigger, timed lamp-index pattern, then cooldown.
// Optional build macro SEQ_LFSR_EN: adds the 8-bit LFSR and random pattern; without it mode 11 runs as up.
module spooky_show_sequencer #(
   parameter int unsigned DWELL_W      = 16,
   parameter int unsigned DEBOUNCE_CYC = 4,
   parameter int unsigned SHOW_STEPS   = 32,
   parameter int unsigned COOL_CYC     = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   spooky_show_sequencer_if.slave bus
);
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);
   localparam int unsigned ST_W = $clog2(SHOW_STEPS + 1);
   localparam int unsigned CL_W = $clog2(COOL_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHOW,
      S_COOL
   } state_e;

   typedef enum logic [1:0] {
      M_UP   = 2'b00,
      M_DOWN = 2'b01,
      M_PING = 2'b10,
      M_RAND = 2'b11
   } mode_e;

   state_e             r_state,  w_state_nxt;
   mode_e              r_mode,   w_mode_nxt;
   logic [1:0]         r_sync;
   logic [DB_W-1:0]    r_db,     w_db_nxt;
   logic [CL_W-1:0]    r_cool,   w_cool_nxt;
   logic [ST_W-1:0]    r_steps,  w_steps_nxt, w_steps_inc;
   logic [DWELL_W-1:0] r_dwell,  w_dwell_nxt;
   logic [DWELL_W-1:0] r_dt,     w_dt_nxt;
   logic [3:0]         r_idx,    w_idx_nxt;
   logic [3:0]         w_step_idx, w_start_idx;
   logic               r_dir_up, w_dir_nxt, w_step_dir;
   logic               r_done,   w_done_nxt;
   logic               w_sync;

   assign w_sync = r_sync[1];

`ifdef SEQ_LFSR_EN
   logic [7:0] r_lfsr;
   logic [3:0] w_rnd;
   logic [3:0] w_rnd_step;

   // Fibonacci taps 8,6,5,4; free-running in every state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= 8'hA5;
      end else begin
         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      end
   end

   assign w_rnd      = r_lfsr[3:0];
   assign w_rnd_step = (w_rnd == r_idx) ? r_idx + 4'd1 : w_rnd;
`endif

   // Pattern stepping from the latched mode, and the entry index from the live mode
   always_comb begin
      w_step_idx  = r_idx + 4'd1;
      w_step_dir  = r_dir_up;
      w_start_idx = 4'd0;
      case (r_mode)
         M_DOWN: w_step_idx = r_idx - 4'd1;
         M_PING: begin
            if (r_dir_up) begin
               if (r_idx == 4'hF) begin
                  w_step_idx = 4'hE;
                  w_step_dir = 1'b0;
               end
            end else if (r_idx == 4'h0) begin
               w_step_idx = 4'h1;
               w_step_dir = 1'b1;
            end else begin
               w_step_idx = r_idx - 4'd1;
            end
         end
`ifdef SEQ_LFSR_EN
         M_RAND: w_step_idx = w_rnd_step;
`endif
         default: ;
      endcase
      case (mode_e'(bus.mode))
         M_DOWN: w_start_idx = 4'hF;
`ifdef SEQ_LFSR_EN
         M_RAND: w_start_idx = w_rnd;
`endif
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_db_nxt    = r_db;
      w_cool_nxt  = r_cool;
      w_steps_nxt = r_steps;
      w_steps_inc = r_steps + ST_W'(1);
      w_dwell_nxt = r_dwell;
      w_dt_nxt    = r_dt;
      w_idx_nxt   = r_idx;
      w_dir_nxt   = r_dir_up;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_sync) begin
               w_db_nxt = '0;
            end else if (r_db == DB_W'(DEBOUNCE_CYC - 1)) begin
               // DEBOUNCE_CYC-th consecutive high sample launches the show on this edge
               w_db_nxt    = '0;
               w_state_nxt = S_SHOW;
               w_mode_nxt  = mode_e'(bus.mode);
               w_dwell_nxt = bus.dwell;
               w_dt_nxt    = '0;
               w_steps_nxt = '0;
               w_idx_nxt   = w_start_idx;
               w_dir_nxt   = 1'b1;
            end else begin
               w_db_nxt = r_db + DB_W'(1);
            end
         end
         S_SHOW: begin
            w_db_nxt = '0;
            if (bus.abort) begin
               w_state_nxt = S_COOL;
               w_cool_nxt  = '0;
            end else if (r_dt == r_dwell) begin
               w_dt_nxt    = '0;
               w_steps_nxt = w_steps_inc;
               if (w_steps_inc == ST_W'(SHOW_STEPS)) begin
                  w_state_nxt = S_COOL;
                  w_cool_nxt  = '0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_idx_nxt = w_step_idx;
                  w_dir_nxt = w_step_dir;
               end
            end else begin
               w_dt_nxt = r_dt + DWELL_W'(1);
            end
         end
         S_COOL: begin
            w_db_nxt = '0;
            if (r_cool == CL_W'(COOL_CYC - 1)) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cool_nxt = r_cool + CL_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_mode   <= M_UP;
         r_sync   <= '0;
         r_db     <= '0;
         r_cool   <= '0;
         r_steps  <= '0;
         r_dwell  <= '0;
         r_dt     <= '0;
         r_idx    <= '0;
         r_dir_up <= 1'b1;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_mode   <= w_mode_nxt;
         r_sync   <= {r_sync[0], bus.motion};
         r_db     <= w_db_nxt;
         r_cool   <= w_cool_nxt;
         r_steps  <= w_steps_nxt;
         r_dwell  <= w_dwell_nxt;
         r_dt     <= w_dt_nxt;
         r_idx    <= w_idx_nxt;
         r_dir_up <= w_dir_nxt;
         r_done   <= w_done_nxt;
      end
   end

   assign bus.lamp_idx = r_idx;
   assign bus.lamp_en  = (r_state == S_SHOW);
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.done     = r_done;
endmodule

// File: tb/tb_spooky_show_sequencer.sv
// Bench for spooky_show_sequencer: timeline model checked every cycle plus literal show-level checks.
`timescale 1ns/1ps
module tb_spooky_show_sequencer;
   localparam int unsigned DW   = 16;
   localparam int          DB   = 4;
   localparam int          SS   = 32;
   localparam int          CC   = 64;
   localparam int          MAXE = 65536;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spooky_show_sequencer_if #(.DWELL_W(DW)) bus ();

   spooky_show_sequencer #(
      .DWELL_W     (DW),
      .DEBOUNCE_CYC(DB),
      .SHOW_STEPS  (SS),
      .COOL_CYC    (CC)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // ---------------- timeline model ----------------
   bit   mh [0:MAXE-1];
   int   e = 0, idle_from = 0, st = 0, cool_until = 0, ldw = 0, lmode = 0, ph = 0;
   int   x_pos = 0, x_idx = 0;
   bit   x_en = 0, x_busy = 0, x_done = 0, x_rand = 0, x_step = 0;

   function automatic int seq_at(input int md, input int p);
      int q;
      case (md)
         1: return 15 - (p % 16);
         2: begin
            q = p % 30;
            return (q < 16) ? q : 30 - q;
         end
         default: return p % 16;
      endcase
   endfunction

   // Trigger seen at edge ee when the raw motion samples DB+1..2 edges back were all high
   function automatic bit win_high(input int ee);
      for (int j = ee - DB - 1; j <= ee - 2; j++) begin
         if (j < 1) return 1'b0;
         if (!mh[j]) return 1'b0;
      end
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e = 0; idle_from = 0; ph = 0; x_idx = 0; x_pos = 0;
         x_en = 0; x_busy = 0; x_done = 0; x_rand = 0; x_step = 0;
      end else begin
         if (e < MAXE - 1) e++;
         mh[e]  = bus.motion;
         x_done = 0;
         x_step = 0;
         case (ph)
            0: if (e - idle_from >= DB && win_high(e)) begin
               ph = 1; st = e; lmode = int'(bus.mode); ldw = int'(bus.dwell);
               x_pos = 0; x_idx = seq_at(lmode, 0);
`ifdef SEQ_LFSR_EN
               x_rand = (lmode == 3);
`endif
            end
            1: if (bus.abort) begin
               ph = 2; cool_until = e + CC;
            end else if (e - st == SS * (ldw + 1)) begin
               ph = 2; cool_until = e + CC; x_done = 1;
            end else begin
               x_step = ((e - st) / (ldw + 1)) != x_pos;
               x_pos  = (e - st) / (ldw + 1);
               x_idx  = seq_at(lmode, x_pos);
            end
            default: if (e == cool_until) begin
               ph = 0; idle_from = e;
            end
         endcase
         x_en   = (ph == 1);
         x_busy = (ph != 0);
      end
   end

   // ---------------- per-cycle compare ----------------
   int prev_idx = 0;
   always @(negedge clk) begin
`ifdef SEQ_LFSR_EN
      if (!x_rand) chk("idx", int'(bus.lamp_idx), x_idx);
      else if (x_step) chk("rand_norepeat", int'(int'(bus.lamp_idx) != prev_idx), 1);
      prev_idx = int'(bus.lamp_idx);
`else
      chk("idx", int'(bus.lamp_idx), x_idx);
`endif
      chk("lamp_en", int'(bus.lamp_en), int'(x_en));
      chk("busy",    int'(bus.busy),    int'(x_busy));
      chk("done",    int'(bus.done),    int'(x_done));
   end

   // ---------------- stimulus ----------------
   task automatic show(input logic [1:0] md, input int dw, input bit hold,
                       input int chg_at, input logic [1:0] chg_md, input int abort_idx,
                       output int rise_d, output int len, output int ndone,
                       output int last, output int cool);
      int k, t;
      @(negedge clk);
      bus.mode   = md;
      bus.dwell  = DW'(dw);
      bus.motion = 1'b1;
      k = cyc + 1;
      t = 0;
      while (!bus.lamp_en && t < 50) begin
         @(negedge clk);
         t++;
      end
      rise_d = cyc - k;
      if (!hold) bus.motion = 1'b0;
      len = 0; ndone = 0;
      while (bus.lamp_en && len < 2000) begin
         len++;
         if (len - 1 == chg_at) bus.mode = chg_md;
         bus.abort = (abort_idx >= 0) && (int'(bus.lamp_idx) == abort_idx);
         @(negedge clk);
         if (bus.done) ndone++;
      end
      bus.abort = 1'b0;
      last = int'(bus.lamp_idx);
      cool = 0;
      while (bus.busy && cool < 500) begin
         cool++;
         @(negedge clk);
         if (bus.done) ndone++;
      end
   endtask

   initial begin
      int rise, len, nd, last, cool, t, x;
      bit seen;
      bus.motion = 1'b0; bus.mode = 2'b00; bus.dwell = '0; bus.abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_idx",  int'(bus.lamp_idx), 0);
      chk("rst_en",   int'(bus.lamp_en),  0);
      chk("rst_busy", int'(bus.busy),     0);
      chk("rst_done", int'(bus.done),     0);
      rst_n = 1'b1;

      // up, dwell 2
      show(2'b00, 2, 1'b0, -1, 2'b00, -1, rise, len, nd, last, cool);
      chk("up_rise", rise, 5);
      chk("up_len",  len, 96);
      chk("up_done", nd, 1);
      chk("up_last", last, 15);
      chk("up_cool", cool, 64);

      // glitch: three high samples only
      @(negedge clk);
      bus.motion = 1'b1;
      repeat (3) @(negedge clk);
      bus.motion = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen |= bus.lamp_en | bus.busy | bus.done;
      end
      chk("glitch_quiet", int'(seen), 0);

      // ping-pong, dwell 0
      show(2'b10, 0, 1'b0, -1, 2'b00, -1, rise, len, nd, last, cool);
      chk("pp_len",  len, 32);
      chk("pp_done", nd, 1);
      chk("pp_last", last, 1);

      // down, mode switched to up at step 3 (ignored)
      show(2'b01, 0, 1'b0, 3, 2'b00, -1, rise, len, nd, last, cool);
      chk("dn_len",  len, 32);
      chk("dn_last", last, 0);

      // abort at index 5, motion held through cooldown
      show(2'b00, 1, 1'b1, -1, 2'b00, 5, rise, len, nd, last, cool);
      chk("ab_len",  len, 11);
      chk("ab_done", nd, 0);
      chk("ab_last", last, 5);
      chk("ab_cool", cool, 64);
      x = cyc;
      t = 0;
      while (!bus.lamp_en && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("ab_restart", cyc - x, 4);
      bus.motion = 1'b0;
      t = 0;
      while (bus.busy && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("ab_second_ends", int'(bus.busy), 0);

      // reset asserted mid-show
      @(negedge clk);
      bus.mode = 2'b00; bus.dwell = DW'(3); bus.motion = 1'b1;
      t = 0;
      while (!bus.lamp_en && t < 50) begin
         @(negedge clk);
         t++;
      end
      repeat (10) @(negedge clk);
      bus.motion = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_idx",  int'(bus.lamp_idx), 0);
      chk("mid_rst_en",   int'(bus.lamp_en),  0);
      chk("mid_rst_busy", int'(bus.busy),     0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // random mode
      show(2'b11, 1, 1'b0, -1, 2'b00, -1, rise, len, nd, last, cool);
      chk("rnd_len",  len, 64);
      chk("rnd_done", nd, 1);
`ifndef SEQ_LFSR_EN
      chk("rnd_last_as_up", last, 15);
`endif

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end
endmodule
